// File: rtl/pipe_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_ctrl : 5-stage pipeline hazard/flush/freeze controller with 2-entry
//             write scoreboard and saturating stall/flush event counters.
// Revision  : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module pipe_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid,
    input  logic [3:0]  id_rs1,
    input  logic [3:0]  id_rs2,
    input  logic        id_rs1_used,
    input  logic        id_rs2_used,
    input  logic [3:0]  id_rd,
    input  logic        id_wr_en,
    input  logic        ex_jump_taken,
    input  logic        mem_busy,
    output logic        pc_en,
    output logic        if_id_en,
    output logic        ex_mem_en,
    output logic        mem_wb_en,
    output logic        if_id_flush,
    output logic        id_ex_flush,
    output logic [1:0]  ctrl_state,
    output logic [15:0] stall_cnt,
    output logic [15:0] flush_cnt
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_HAZ   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_WAIT  = 2'd3
    } state_t;

    localparam logic [15:0] C_CNT_MAX = 16'hFFFF;

    logic        r_ex_vld;
    logic [3:0]  r_ex_rd;
    logic        r_mem_vld;
    logic [3:0]  r_mem_rd;
    logic [15:0] r_stall_cnt;
    logic [15:0] r_flush_cnt;
    state_t      r_state;

    logic        w_hit1;
    logic        w_hit2;
    logic        w_hazard;
    state_t      w_cls;

    // WB needs no entry: the register file forwards a same-cycle write to reads.
    assign w_hit1 = id_rs1_used && ((r_ex_vld  && (id_rs1 == r_ex_rd)) ||
                                    (r_mem_vld && (id_rs1 == r_mem_rd)));
    assign w_hit2 = id_rs2_used && ((r_ex_vld  && (id_rs2 == r_ex_rd)) ||
                                    (r_mem_vld && (id_rs2 == r_mem_rd)));
    assign w_hazard = id_valid && (w_hit1 || w_hit2);

    always_comb begin
        if (mem_busy)           w_cls = ST_WAIT;
        else if (ex_jump_taken) w_cls = ST_FLUSH;
        else if (w_hazard)      w_cls = ST_HAZ;
        else                    w_cls = ST_RUN;
    end

    always_comb begin
        pc_en       = 1'b0;
        if_id_en    = 1'b0;
        ex_mem_en   = 1'b0;
        mem_wb_en   = 1'b0;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        if (!rst) begin
            case (w_cls)
                ST_RUN: begin
                    pc_en     = 1'b1;
                    if_id_en  = 1'b1;
                    ex_mem_en = 1'b1;
                    mem_wb_en = 1'b1;
                end
                ST_HAZ: begin
                    ex_mem_en   = 1'b1;
                    mem_wb_en   = 1'b1;
                    id_ex_flush = 1'b1;
                end
                ST_FLUSH: begin
                    pc_en       = 1'b1;
                    ex_mem_en   = 1'b1;
                    mem_wb_en   = 1'b1;
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ex_vld    <= 1'b0;
            r_ex_rd     <= 4'd0;
            r_mem_vld   <= 1'b0;
            r_mem_rd    <= 4'd0;
            r_stall_cnt <= 16'd0;
            r_flush_cnt <= 16'd0;
            r_state     <= ST_RUN;
        end else begin
            r_state <= w_cls;
            // The frozen pipeline keeps both scoreboard entries in place.
            if (w_cls != ST_WAIT) begin
                r_mem_vld <= r_ex_vld;
                r_mem_rd  <= r_ex_rd;
                if (w_cls == ST_RUN) begin
                    r_ex_vld <= id_valid && id_wr_en;
                    r_ex_rd  <= id_rd;
                end else begin
                    r_ex_vld <= 1'b0;
                end
            end
            if (((w_cls == ST_HAZ) || (w_cls == ST_WAIT)) && (r_stall_cnt != C_CNT_MAX))
                r_stall_cnt <= r_stall_cnt + 16'd1;
            if ((w_cls == ST_FLUSH) && (r_flush_cnt != C_CNT_MAX))
                r_flush_cnt <= r_flush_cnt + 16'd1;
        end
    end

    assign ctrl_state = r_state;
    assign stall_cnt  = r_stall_cnt;
    assign flush_cnt  = r_flush_cnt;

endmodule

`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipe_ctrl : directed + random checks of pipe_ctrl against an
//                instruction-level model of the in-flight writes.
// Revision     : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        id_valid = 1'b0;
    logic [3:0]  id_rs1 = 4'd0;
    logic [3:0]  id_rs2 = 4'd0;
    logic        id_rs1_used = 1'b0;
    logic        id_rs2_used = 1'b0;
    logic [3:0]  id_rd = 4'd0;
    logic        id_wr_en = 1'b0;
    logic        ex_jump_taken = 1'b0;
    logic        mem_busy = 1'b0;
    logic        pc_en, if_id_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush;
    logic [1:0]  ctrl_state;
    logic [15:0] stall_cnt, flush_cnt;

    pipe_ctrl u_dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .id_rd(id_rd), .id_wr_en(id_wr_en),
        .ex_jump_taken(ex_jump_taken), .mem_busy(mem_busy),
        .pc_en(pc_en), .if_id_en(if_id_en), .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en),
        .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
        .ctrl_state(ctrl_state), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Model: destination of the instruction now in EX / MEM, -1 when none.
    int m_ex = -1;
    int m_mem = -1;
    int m_stall = 0;
    int m_flush = 0;
    int m_state = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [5:0] ctl_vec();
        return {pc_en, if_id_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush};
    endfunction

    function automatic int classify();
        bit haz;
        haz = id_valid && ((id_rs1_used && (int'(id_rs1) == m_ex || int'(id_rs1) == m_mem)) ||
                           (id_rs2_used && (int'(id_rs2) == m_ex || int'(id_rs2) == m_mem)));
        if (mem_busy)      return 3;
        if (ex_jump_taken) return 2;
        if (haz)           return 1;
        return 0;
    endfunction

    // {pc, if_id, ex_mem, mem_wb, if_id_flush, id_ex_flush} for each class.
    function automatic logic [5:0] exp_vec(input int cls);
        case (cls)
            0:       return 6'b111100;
            1:       return 6'b001101;
            2:       return 6'b101111;
            default: return 6'b000000;
        endcase
    endfunction

    task automatic model_reset();
        m_ex = -1; m_mem = -1; m_stall = 0; m_flush = 0; m_state = 0;
    endtask

    // Called at posedge+1: drive, check combinational outputs, clock, update model.
    task automatic step(input bit v, input int rs1, input int rs2, input bit u1, input bit u2,
                        input int rd, input bit wr, input bit jmp, input bit busy, input bit chk);
        int cls;
        id_valid = v; id_rs1 = 4'(rs1); id_rs2 = 4'(rs2);
        id_rs1_used = u1; id_rs2_used = u2; id_rd = 4'(rd); id_wr_en = wr;
        ex_jump_taken = jmp; mem_busy = busy;
        #3;
        cls = classify();
        if (chk) begin
            check("ctl", {26'd0, ctl_vec()}, {26'd0, exp_vec(cls)});
            check("state", {30'd0, ctrl_state}, m_state);
            check("stall", {16'd0, stall_cnt}, m_stall);
            check("flush", {16'd0, flush_cnt}, m_flush);
        end
        @(posedge clk);
        if (cls != 3) begin
            m_mem = m_ex;
            m_ex  = (cls == 0 && v && wr) ? rd : -1;
        end
        if ((cls == 1 || cls == 3) && m_stall < 65535) m_stall++;
        if (cls == 2 && m_flush < 65535) m_flush++;
        m_state = cls;
        #1;
    endtask

    task automatic wr_op(input int rd);
        step(1, 0, 0, 0, 0, rd, 1, 0, 0, 1);
    endtask

    task automatic rd_op(input int rs, input bit jmp);
        step(1, rs, rs, 1, 0, 15, 0, jmp, 0, 1);
    endtask

    task automatic nop_op();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        check("rst_ctl", {26'd0, ctl_vec()}, 32'd0);
        check("rst_cnt", {stall_cnt, flush_cnt}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        #2;
        check("rst_state", {30'd0, ctrl_state}, 32'd0);
        do_reset();

        // Back-to-back dependency: two HAZ cycles then RUN.
        wr_op(2);
        rd_op(2, 0);
        rd_op(2, 0);
        rd_op(2, 0);
        check("b2b_stall", {16'd0, stall_cnt}, 32'd2);

        do_reset();
        wr_op(1);
        nop_op();
        rd_op(1, 0);
        rd_op(1, 0);
        check("gap_stall", {16'd0, stall_cnt}, 32'd1);

        // Jump beats a coincident hazard.
        do_reset();
        wr_op(3);
        rd_op(3, 1);
        check("jmp_state", {30'd0, ctrl_state}, 32'd2);
        check("jmp_cnts", {stall_cnt, flush_cnt}, {16'd0, 16'd1});
        nop_op();

        // Freeze with pending write and jump held: everything stalls, nothing flushes.
        do_reset();
        wr_op(4);
        for (int i = 0; i < 3; i++) step(1, 4, 0, 1, 0, 0, 0, 1, 1, 1);
        check("wait_cnts", {stall_cnt, flush_cnt}, {16'd3, 16'd0});
        rd_op(4, 0);
        rd_op(4, 0);
        check("wait_hold", {16'd0, stall_cnt}, 32'd5);

        // Async reset in the middle of a HAZ cycle.
        do_reset();
        wr_op(5);
        id_valid = 1; id_rs1 = 4'd5; id_rs1_used = 1; id_rs2_used = 0; id_wr_en = 0;
        #2;
        check("pre_rst_haz", {26'd0, ctl_vec()}, {26'd0, exp_vec(1)});
        rst = 1'b1;
        #1;
        check("async_ctl", {26'd0, ctl_vec()}, 32'd0);
        check("async_state", {30'd0, ctrl_state}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        rd_op(5, 0);
        check("stale_stall", {16'd0, stall_cnt}, 32'd0);

        // Random traffic against the model.
        for (int i = 0; i < 2000; i++) begin
            step($urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 3),
                 $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 3),
                 $urandom_range(0, 1), ($urandom_range(0, 9) == 0),
                 ($urandom_range(0, 7) == 0), 1);
        end

        // Counter saturation.
        do_reset();
        for (int i = 0; i < 70000; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        check("sat_stall", {16'd0, stall_cnt}, 32'h0000_FFFF);
        nop_op();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, with ports as listed below.
REQ-002 clk  in  1  single clock; all state SHALL update on the rising edge.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 id_valid  in  1  ID stage holds a real instruction.
REQ-005 id_rs1 / id_rs2  in  4 each  source register indices of the ID instruction.
REQ-006 id_rs1_used / id_rs2_used  in  1 each  the corresponding source is read.
REQ-007 id_rd  in  4  destination register index of the ID instruction.
REQ-008 id_wr_en  in  1  the ID instruction writes id_rd.
REQ-009 ex_jump_taken  in  1  EX resolved a taken jump or branch this cycle.
REQ-010 mem_busy  in  1  data memory not ready; MEM cannot retire.
REQ-011 pc_en, if_id_en, ex_mem_en, mem_wb_en  out  1 each  stage register load enables.
REQ-012 if_id_flush, id_ex_flush  out  1 each  load a bubble into IF/ID or ID/EX.
REQ-013 ctrl_state  out  2  registered class of the previous cycle: 0 RUN, 1 HAZ, 2 FLUSH, 3 WAIT.
REQ-014 stall_cnt, flush_cnt  out  16 each  saturating event counters.

Function
REQ-015 The scoreboard SHALL hold two entries, sb_ex and sb_mem, each {valid, rd[3:0]}, tracking pending writes in EX and MEM; WB writes need no tracking because the register file is write-first.
REQ-016 A hazard SHALL exist when id_valid=1 and a used source equals the rd of a valid sb_ex or sb_mem entry; R0 is an ordinary register and participates.
REQ-017 Cycle classification SHALL be combinational with priority WAIT (mem_busy=1) > FLUSH (ex_jump_taken=1) > HAZ (hazard) > RUN.
REQ-018 RUN: all four enables =1, both flushes =0; sb_mem<=sb_ex; sb_ex<={id_valid&id_wr_en, id_rd}.
REQ-019 HAZ: pc_en=0, if_id_en=0, id_ex_flush=1, ex_mem_en=1, mem_wb_en=1; sb_mem<=sb_ex; sb_ex<=invalid; stall_cnt increments.
REQ-020 FLUSH: pc_en=1 (the PC loads the jump target), if_id_flush=1, id_ex_flush=1, ex_mem_en=1, mem_wb_en=1; sb_mem<=sb_ex; sb_ex<=invalid; flush_cnt increments.
REQ-021 WAIT: all enables =0 and both flushes =0; scoreboard holds; stall_cnt increments; a coincident ex_jump_taken SHALL be ignored, and EX SHALL keep asserting it until the freeze ends.
REQ-022 ctrl_state SHALL register the class of each cycle, giving it one cycle of latency.
REQ-023 Counters SHALL saturate at 16'hFFFF and never wrap.
REQ-024 Flush and enable outputs SHALL be combinational from the inputs and scoreboard, with zero-cycle latency.
REQ-025 A hazard against sb_mem alone SHALL resolve after one HAZ cycle; a hazard against sb_ex SHALL resolve after two HAZ cycles.

Reset
REQ-026 While rst=1: scoreboard entries invalid, counters 0, ctrl_state=RUN, all enables 0, both flushes 0.
REQ-027 Reset asserted mid-operation SHALL clear state immediately regardless of clk; the first edge after release SHALL behave as RUN with an empty scoreboard.

Verification
REQ-028 Release reset, issue write R2 then a read of R2 back-to-back -> two HAZ cycles (pc_en=0, id_ex_flush=1), then RUN; stall_cnt=2.
REQ-029 Write R1, an independent instruction, then a read of R1 -> exactly one HAZ cycle; stall_cnt=1.
REQ-030 ex_jump_taken=1 for one cycle while a hazard is also present -> FLUSH wins: if_id_flush=1, id_ex_flush=1, pc_en=1; flush_cnt=1, stall_cnt unchanged; ctrl_state=2 on the next cycle.
REQ-031 mem_busy=1 for 3 cycles with a valid sb_ex and ex_jump_taken=1 -> all enables 0 for 3 cycles, scoreboard unchanged, stall_cnt=3, flush_cnt=0.
REQ-032 Hold mem_busy=1 for 70000 cycles -> stall_cnt saturates at 16'hFFFF.
REQ-033 Assert rst asynchronously during a HAZ cycle -> outputs go to reset values before the next edge; after release, a read of the stale rd causes no stall.
